// File: rtl/trivium_stream_cipher_if.sv
// Valid/ready word path of the Trivium engine.
// Words enter on in_* and leave keystream-XORed on out_*.
interface trivium_stream_cipher_if #(
  parameter int W = 8
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;

  modport master (
    output in_valid,
    output in_data,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data
  );
endinterface

// File: rtl/trivium_stream_cipher.sv
// Trivium stream cipher: W keystream bits per clock XORed onto a
// valid/ready word stream, with key/IV warm-up and a per-key word limit.
module trivium_stream_cipher #(
  parameter int W          = 8,
  parameter int INIT_STEPS = 1152,
  parameter int CNT_W      = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [79:0] key,
  input  logic [79:0] iv,
  trivium_stream_cipher_if.slave bus,
  output logic        busy,
  output logic        rekey_req,
  output logic        err
);
  localparam int INIT_CYCLES = INIT_STEPS / W;
  localparam int ICW = $clog2(INIT_CYCLES + 1);
  localparam logic [ICW-1:0] INIT_LAST = ICW'(INIT_CYCLES - 1);
  // Count reached just before the limit; the next handshake exhausts the key.
  localparam logic [CNT_W-1:0] CNT_LAST = {{(CNT_W-1){1'b1}}, 1'b0};

  typedef enum logic [1:0] {
    IDLE,
    INIT,
    RUN,
    EXHAUSTED
  } state_t;

  state_t           state_q, state_d;
  logic [287:0]     s_q, s_d;
  logic [287:0]     adv_s, load_img;
  logic [ICW-1:0]   cnt_init_q, cnt_init_d;
  logic [CNT_W-1:0] word_cnt_q, word_cnt_d;
  logic             out_valid_q, out_valid_d;
  logic [W-1:0]     out_data_q, out_data_d;
  logic             err_q, err_d;
  logic             busy_q, busy_d;
  logic             rekey_q, rekey_d;
  logic [W-1:0]     ks;
  logic [288:0]     step_r;
  logic             in_ready;
  logic             hs;

  // Bit n-1 of the vector holds Trivium state bit s_n; result bit 288 is z.
  function automatic logic [288:0] trivium_step(input logic [287:0] s);
    logic t1, t2, t3, z;
    t1 = s[65] ^ s[92];
    t2 = s[161] ^ s[176];
    t3 = s[242] ^ s[287];
    z  = t1 ^ t2 ^ t3;
    t1 = t1 ^ (s[90] & s[91]) ^ s[170];
    t2 = t2 ^ (s[174] & s[175]) ^ s[263];
    t3 = t3 ^ (s[285] & s[286]) ^ s[68];
    return {z, s[286:177], t2, s[175:93], t1, s[91:0], t3};
  endfunction

  assign load_img = {3'b111, 112'd0, iv, 13'd0, key};

  always_comb begin
    adv_s  = s_q;
    ks     = '0;
    step_r = '0;
    for (int i = 0; i < W; i++) begin
      step_r = trivium_step(adv_s);
      ks[i]  = step_r[288];
      adv_s  = step_r[287:0];
    end
  end

  assign in_ready = (state_q == RUN)
                 && (!out_valid_q || bus.out_ready);
  assign hs = bus.in_valid && in_ready;

  always_comb begin
    state_d     = state_q;
    s_d         = s_q;
    cnt_init_d  = cnt_init_q;
    word_cnt_d  = word_cnt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    err_d       = err_q;

    if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end
    if (bus.in_valid && (state_q != RUN)) begin
      err_d = 1'b1;
    end

    unique case (state_q)
      IDLE: begin
      end
      INIT: begin
        s_d        = adv_s;
        cnt_init_d = cnt_init_q + ICW'(1);
        if (cnt_init_q == INIT_LAST) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (hs) begin
          s_d         = adv_s;
          out_data_d  = bus.in_data ^ ks;
          out_valid_d = 1'b1;
          word_cnt_d  = word_cnt_q + CNT_W'(1);
          if (word_cnt_q == CNT_LAST) begin
            state_d = EXHAUSTED;
          end
        end
      end
      EXHAUSTED: begin
      end
    endcase

    // A load restarts the cipher from any state and drops a pending word.
    if (load) begin
      s_d         = load_img;
      cnt_init_d  = '0;
      word_cnt_d  = '0;
      out_valid_d = 1'b0;
      err_d       = 1'b0;
      state_d     = INIT;
    end

    busy_d  = (state_d == INIT);
    rekey_d = (state_d == EXHAUSTED);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      s_q         <= '0;
      cnt_init_q  <= '0;
      word_cnt_q  <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
      rekey_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      s_q         <= s_d;
      cnt_init_q  <= cnt_init_d;
      word_cnt_q  <= word_cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
      rekey_q     <= rekey_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign busy          = busy_q;
  assign rekey_req     = rekey_q;
  assign err           = err_q;
endmodule

// File: tb/tb_trivium_stream_cipher.sv
// Bench for trivium_stream_cipher: W=8 instance scoreboarded against a
// three-register Trivium model, W=64/CNT_W=4 instance for limit handling.
module tb_trivium_stream_cipher;
  localparam int KS_N = 2048;
  typedef bit [KS_N-1:0] ks_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        a_load, b_load;
  logic [79:0] a_key, a_iv, b_key, b_iv;
  logic        a_busy, a_rekey, a_err;
  logic        b_busy, b_rekey, b_err;

  trivium_stream_cipher_if #(.W(8))  ifa ();
  trivium_stream_cipher_if #(.W(64)) ifb ();

  trivium_stream_cipher #(
    .W(8), .INIT_STEPS(1152), .CNT_W(16)
  ) dut_a (
    .clk(clk), .rst(rst), .load(a_load),
    .key(a_key), .iv(a_iv), .bus(ifa),
    .busy(a_busy), .rekey_req(a_rekey), .err(a_err)
  );

  trivium_stream_cipher #(
    .W(64), .INIT_STEPS(1152), .CNT_W(4)
  ) dut_b (
    .clk(clk), .rst(rst), .load(b_load),
    .key(b_key), .iv(b_iv), .bus(ifb),
    .busy(b_busy), .rekey_req(b_rekey), .err(b_err)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name,
                     input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Trivium as three shift registers A(93) B(84) C(111), 1-based.
  function automatic ks_t gen_ks(input bit [79:0] k,
                                 input bit [79:0] v,
                                 input int warm);
    bit a [1:93];
    bit b [1:84];
    bit c [1:111];
    bit t1, t2, t3, z;
    ks_t r = '0;
    for (int i = 1; i <= 93; i++) a[i] = (i <= 80) ? k[i-1] : 1'b0;
    for (int i = 1; i <= 84; i++) b[i] = (i <= 80) ? v[i-1] : 1'b0;
    for (int i = 1; i <= 111; i++) c[i] = (i >= 109);
    for (int n = 0; n < warm + KS_N; n++) begin
      t1 = a[66] ^ a[93];
      t2 = b[69] ^ b[84];
      t3 = c[66] ^ c[111];
      z  = t1 ^ t2 ^ t3;
      t1 = t1 ^ (a[91] & a[92]) ^ b[78];
      t2 = t2 ^ (b[82] & b[83]) ^ c[87];
      t3 = t3 ^ (c[109] & c[110]) ^ a[69];
      for (int i = 93; i > 1; i--) a[i] = a[i-1];
      for (int i = 84; i > 1; i--) b[i] = b[i-1];
      for (int i = 111; i > 1; i--) c[i] = c[i-1];
      a[1] = t3;
      b[1] = t1;
      c[1] = t2;
      if (n >= warm) r[n-warm] = z;
    end
    return r;
  endfunction

  ks_t        m_ks;
  int         m_pos = 0;
  logic [7:0] exp_q[$];
  logic [7:0] cap_q[$];
  logic       prev_hold = 1'b0;
  logic [7:0] prev_data = '0;

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_q.delete();
        prev_hold = 1'b0;
      end else begin
        if (ifa.out_valid) begin
          chk("a_word_expected", 128'(exp_q.size() > 0), 1);
          if (exp_q.size() > 0) chk("a_out_data", ifa.out_data, exp_q[0]);
          if (prev_hold) chk("a_hold_stable", ifa.out_data, prev_data);
          if (ifa.out_ready) begin
            if (exp_q.size() > 0) void'(exp_q.pop_front());
            cap_q.push_back(ifa.out_data);
          end
        end else begin
          chk("a_no_lost_word", exp_q.size(), 0);
        end
        prev_hold = ifa.out_valid && !ifa.out_ready;
        prev_data = ifa.out_data;
        if (a_load) begin
          m_ks = gen_ks(a_key, a_iv, 1152);
          m_pos = 0;
          exp_q.delete();
          prev_hold = 1'b0;
        end else if (ifa.in_valid && ifa.in_ready) begin
          exp_q.push_back(ifa.in_data ^ m_ks[m_pos +: 8]);
          m_pos += 8;
        end
      end
    end
  end

  logic [7:0] src [0:127];
  logic [7:0] pt  [0:127];

  task automatic a_do_load(input logic [79:0] k, input logic [79:0] v);
    @(posedge clk); #1;
    a_load = 1'b1; a_key = k; a_iv = v;
    @(posedge clk); #1;
    a_load = 1'b0;
  endtask

  task automatic a_wait_run(input int exp_len);
    int n = 0;
    bit done = 1'b0;
    for (int c = 0; c < 5000 && !done; c++) begin
      @(negedge clk);
      if (a_busy) n++;
      else done = 1'b1;
    end
    chk("a_init_done", done, 1);
    chk("a_busy_cycles", n, exp_len);
    chk("a_in_ready_after_init", ifa.in_ready, 1);
  endtask

  task automatic a_stream(input int n, input int vld_pct, input int rdy_pct);
    int idx = 0;
    for (int g = 0; g < 20000 && idx < n; g++) begin
      @(posedge clk); #1;
      ifa.in_valid  = ($urandom_range(99) < vld_pct);
      ifa.in_data   = src[idx];
      ifa.out_ready = ($urandom_range(99) < rdy_pct);
      @(negedge clk);
      if (ifa.in_valid && ifa.in_ready) idx++;
    end
    chk("a_stream_done", idx, n);
    @(posedge clk); #1;
    ifa.in_valid  = 1'b0;
    ifa.out_ready = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    ks_t ks;
    ks_t bks;
    logic [79:0] k3, v3;
    logic [63:0] d;
    int bad;
    int n;
    bit done;

    rst = 1'b1;
    a_load = 0; a_key = '0; a_iv = '0;
    b_load = 0; b_key = '0; b_iv = '0;
    ifa.in_valid = 0; ifa.in_data = '0; ifa.out_ready = 1;
    ifb.in_valid = 0; ifb.in_data = '0; ifb.out_ready = 1;

    ks = gen_ks('0, '0, 0);
    chk("pin_zero_z0_z3", ks[3:0], 4'b0111);
    chk("pin_zero_z4_z7", ks[7:4], 4'b0000);
    ks = gen_ks(80'd1 << 65, '0, 0);
    chk("pin_k66_z0_z1", ks[1:0], 2'b10);
    ks = gen_ks('0, 80'd1 << 68, 0);
    chk("pin_iv69_z0", ks[0], 1'b0);

    repeat (3) @(negedge clk);
    chk("rst_a_in_ready", ifa.in_ready, 0);
    chk("rst_a_out_valid", ifa.out_valid, 0);
    chk("rst_a_out_data", ifa.out_data, 0);
    chk("rst_a_busy", a_busy, 0);
    chk("rst_a_rekey", a_rekey, 0);
    chk("rst_a_err", a_err, 0);
    chk("rst_b_flags", {b_busy, b_rekey, b_err, ifb.out_valid}, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // in_valid while idle is misuse
    @(posedge clk); #1; ifa.in_valid = 1'b1;
    @(posedge clk); #1; ifa.in_valid = 1'b0;
    @(negedge clk);
    chk("a_err_idle", a_err, 1);

    a_do_load('0, '0);
    @(negedge clk);
    chk("a_err_cleared_by_load", a_err, 0);
    chk("a_busy_after_load", a_busy, 1);
    a_wait_run(143);
    for (int i = 0; i < 128; i++) src[i] = 8'h00;
    a_stream(16, 100, 100);

    a_do_load(80'h8000_0000_0000_0000_0000, '0);
    a_wait_run(144);
    a_stream(64, 100, 100);

    // encrypt, reload, decrypt
    k3 = 80'h0123_4567_89ab_cdef_fedc;
    v3 = 80'h5a5a_0f0f_3c3c_a5a5_1234;
    ks = gen_ks(k3, v3, 1152);
    for (int i = 0; i < 128; i++) begin
      pt[i]  = 8'($urandom);
      src[i] = pt[i];
    end
    a_do_load(k3, v3);
    a_wait_run(144);
    a_stream(100, 100, 100);
    for (int i = 0; i < 100; i++) src[i] = pt[i] ^ ks[8*i +: 8];
    a_do_load(k3, v3);
    a_wait_run(144);
    cap_q.delete();
    a_stream(100, 100, 100);
    chk("a_roundtrip_count", cap_q.size(), 100);
    bad = 0;
    for (int i = 0; i < 100 && i < cap_q.size(); i++) begin
      if (cap_q[i] !== pt[i]) bad++;
    end
    chk("a_roundtrip_bad_words", bad, 0);

    // random backpressure and gaps
    for (int i = 0; i < 128; i++) src[i] = 8'($urandom);
    a_do_load(80'hdead_beef_0bad_f00d_cafe, 80'h0000_1111_2222_3333_4444);
    a_wait_run(144);
    a_stream(60, 50, 50);

    // load while a word is held drops it
    @(posedge clk); #1;
    ifa.in_valid = 1'b1; ifa.in_data = 8'h3c; ifa.out_ready = 1'b0;
    @(posedge clk); #1;
    ifa.in_valid = 1'b0;
    @(negedge clk);
    chk("a_held_valid", ifa.out_valid, 1);
    a_do_load(80'h1357_9bdf_2468_ace0_1122, 80'h99aa_bbcc_ddee_ff00_7788);
    @(negedge clk);
    chk("a_drop_on_load", ifa.out_valid, 0);
    a_wait_run(143);
    for (int i = 0; i < 128; i++) src[i] = 8'h00;
    a_stream(8, 100, 100);

    // rst in the middle of INIT
    a_do_load(80'h0f0f_0f0f_0f0f_0f0f_0f0f, '0);
    repeat (10) @(posedge clk);
    #1; ifa.in_valid = 1'b1;
    @(posedge clk); #1; ifa.in_valid = 1'b0;
    @(negedge clk);
    chk("a_err_init", a_err, 1);
    chk("a_busy_mid_init", a_busy, 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", a_busy, 0);
    chk("arst_err", a_err, 0);
    chk("arst_out_data", ifa.out_data, 0);
    chk("arst_flags", {ifa.in_ready, ifa.out_valid, a_rekey}, 0);
    @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b0;

    // W=64 with a 15-word limit
    b_key = 80'h8000_0000_0000_0000_0000;
    b_iv  = '0;
    bks = gen_ks(b_key, b_iv, 1152);
    @(posedge clk); #1; b_load = 1'b1;
    @(posedge clk); #1; b_load = 1'b0;
    n = 0; done = 1'b0;
    for (int c = 0; c < 500 && !done; c++) begin
      @(negedge clk);
      if (b_busy) n++;
      else done = 1'b1;
    end
    chk("b_busy_cycles", n, 18);
    for (int w = 0; w < 15; w++) begin
      @(posedge clk); #1;
      d = {$urandom, $urandom};
      ifb.in_valid = 1'b1; ifb.in_data = d;
      @(negedge clk);
      chk("b_in_ready", ifb.in_ready, 1);
      @(posedge clk); #1;
      ifb.in_valid = 1'b0;
      @(negedge clk);
      chk("b_out_valid", ifb.out_valid, 1);
      chk("b_out_data", ifb.out_data, d ^ bks[w*64 +: 64]);
      chk("b_rekey", b_rekey, (w == 14));
    end
    chk("b_in_ready_exh", ifb.in_ready, 0);
    chk("b_err_before", b_err, 0);
    @(negedge clk);
    chk("b_drained", ifb.out_valid, 0);
    @(posedge clk); #1; ifb.in_valid = 1'b1;
    @(negedge clk);
    chk("b_in_ready_blocked", ifb.in_ready, 0);
    @(posedge clk); #1; ifb.in_valid = 1'b0;
    @(negedge clk);
    chk("b_err_exh", b_err, 1);
    chk("b_rekey_held", b_rekey, 1);
    @(posedge clk); #1; b_load = 1'b1;
    @(posedge clk); #1; b_load = 1'b0;
    @(negedge clk);
    chk("b_busy_reload", b_busy, 1);
    chk("b_rekey_cleared", b_rekey, 0);
    chk("b_err_cleared", b_err, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
